// File: rtl/branch_resolver.sv
// In-order tracker for conditional branches between fetch and execute.
// It drives the 2-bit predictor, queues predicted directions and flushes younger branches on a misprediction.
module branch_resolver #(
   parameter int ADDR_W = 2,
   parameter int STAT_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              br_valid,
   output logic              br_ready,
   output logic              pred_valid,
   output logic              pred_taken,
   input  logic              res_valid,
   input  logic              res_taken,
   output logic              res_ready,
   output logic              mispredict,
   output logic              request,
   output logic              result,
   output logic              taken,
   input  logic              prediction,
   output logic [ADDR_W:0]   count,
   output logic [STAT_W-1:0] resolved_cnt,
   output logic [STAT_W-1:0] mispred_cnt
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W+1:0] OCC_FULL = (ADDR_W+2)'(DEPTH);

   logic [DEPTH-1:0]  queue_q, queue_d;
   logic [ADDR_W-1:0] head_q, head_d;
   logic [ADDR_W-1:0] tail_q, tail_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              pending_q, pending_d;
   logic              mispredict_q, mispredict_d;
   logic [STAT_W-1:0] resolved_cnt_q, resolved_cnt_d;
   logic [STAT_W-1:0] mispred_cnt_q, mispred_cnt_d;

   logic [ADDR_W+1:0] occupancy;
   logic              accept;
   logic              capture;
   logic              resolve;
   logic              wrong;

   // Handshakes: a branch transfers when br_valid & br_ready, a resolve when
   // res_valid & res_ready; neither ready depends on its own valid.
   assign occupancy  = {1'b0, count_q} + {{(ADDR_W+1){1'b0}}, pending_q};
   assign br_ready   = !reset && !mispredict_q && (occupancy < OCC_FULL);
   assign accept     = br_valid && br_ready;
   assign capture    = pending_q;
   assign res_ready  = (count_q != '0);
   assign resolve    = res_valid && res_ready;
   assign wrong      = resolve && (queue_q[head_q] != res_taken);

   assign request    = accept;
   assign pred_valid = pending_q;
   assign pred_taken = prediction;
   assign result     = resolve;
   assign taken      = resolve && res_taken;
   assign mispredict = mispredict_q;
   assign count      = count_q;
   assign resolved_cnt = resolved_cnt_q;
   assign mispred_cnt  = mispred_cnt_q;

   always_comb begin
      queue_d        = queue_q;
      head_d         = head_q;
      tail_d         = tail_q;
      count_d        = count_q + (ADDR_W+1)'(capture) - (ADDR_W+1)'(resolve);
      pending_d      = accept;
      mispredict_d   = wrong;
      resolved_cnt_d = resolved_cnt_q;
      mispred_cnt_d  = mispred_cnt_q;

      if (capture) begin
         queue_d[tail_q] = prediction;
         tail_d          = tail_q + ADDR_W'(1);
      end

      if (resolve) begin
         head_d = head_q + ADDR_W'(1);
         if (resolved_cnt_q != '1) resolved_cnt_d = resolved_cnt_q + STAT_W'(1);
      end

      // Everything younger than a wrong-path branch is discarded, including a capture this cycle.
      if (wrong) begin
         head_d    = '0;
         tail_d    = '0;
         count_d   = '0;
         pending_d = 1'b0;
         if (mispred_cnt_q != '1) mispred_cnt_d = mispred_cnt_q + STAT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         queue_q        <= '0;
         head_q         <= '0;
         tail_q         <= '0;
         count_q        <= '0;
         pending_q      <= 1'b0;
         mispredict_q   <= 1'b0;
         resolved_cnt_q <= '0;
         mispred_cnt_q  <= '0;
      end else begin
         queue_q        <= queue_d;
         head_q         <= head_d;
         tail_q         <= tail_d;
         count_q        <= count_d;
         pending_q      <= pending_d;
         mispredict_q   <= mispredict_d;
         resolved_cnt_q <= resolved_cnt_d;
         mispred_cnt_q  <= mispred_cnt_d;
      end
   end

endmodule
